// File: rtl/gtech_tree_pkg.sv
// Shared constants and elaboration-time sizing helpers for the AND4 reduction tree.
package gtech_tree_pkg;

  localparam int FANIN      = 4;
  localparam int MAX_LEVELS = 16;

  // Width of the vector entering level k of a tree fed with 'width' bits.
  function automatic int level_width(input int width, input int k);
    int w;
    w = width;
    for (int i = 0; i < MAX_LEVELS; i++) begin
      if (i < k) w = (w + FANIN - 1) / FANIN;
    end
    return w;
  endfunction

  // Number of AND4 levels needed to reach a single bit; never less than one.
  function automatic int clog4(input int n);
    int l;
    l = 0;
    for (int i = 0; i < MAX_LEVELS; i++) begin
      if (level_width(n, i) > 1) l = i + 1;
    end
    return (l < 1) ? 1 : l;
  endfunction

endpackage

// File: rtl/gtech_and4_pipe_stage.sv
// One tree level: AND4 groups (LSB-first, 1-padded) into a data/tag/valid register.
// Latency 1 cycle; loads whenever empty or when downstream takes the held word.
module gtech_and4_pipe_stage
  import gtech_tree_pkg::*;
#(
  parameter int WIN  = 64,
  parameter int TAGW = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              up_vld_i,
  output logic                              up_rdy_o,
  input  logic [WIN-1:0]                    up_dat_i,
  input  logic [TAGW-1:0]                   up_tag_i,
  output logic                              dn_vld_o,
  input  logic                              dn_rdy_i,
  output logic [(WIN+FANIN-1)/FANIN-1:0]    dn_dat_o,
  output logic [TAGW-1:0]                   dn_tag_o
);

  localparam int WOUT = (WIN + FANIN - 1) / FANIN;

  logic [WOUT*FANIN-1:0] padded;
  logic [WOUT-1:0]       and_d;
  logic [WOUT-1:0]       dat_q;
  logic [TAGW-1:0]       tag_q;
  logic                  vld_q;
  logic                  load;

  // Missing bits of the top group read as 1 so they never pull the result low.
  always_comb begin
    padded             = '1;
    padded[WIN-1:0]    = up_dat_i;
  end

  for (genvar g = 0; g < WOUT; g++) begin : g_and4
    assign and_d[g] = &padded[g*FANIN +: FANIN];
  end

  assign load     = !vld_q || dn_rdy_i;
  assign up_rdy_o = load;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= 1'b0;
      dat_q <= '0;
      tag_q <= '0;
    end else if (load) begin
      vld_q <= up_vld_i;
      dat_q <= and_d;
      tag_q <= up_tag_i;
    end
  end

  assign dn_vld_o = vld_q;
  assign dn_dat_o = dat_q;
  assign dn_tag_o = tag_q;

endmodule

// File: rtl/gtech_and4_tree_pipe.sv
// Pipelined AND-reduction of IN_DATA to Z with tag passthrough; LEVELS-cycle latency.
// Full throughput; IN_READY is combinational from OUT_READY through the valid chain.
module gtech_and4_tree_pipe
  import gtech_tree_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int TAGW  = 4
) (
  input  logic             CP,
  input  logic             CD,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic [TAGW-1:0]  IN_TAG,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             Z,
  output logic [TAGW-1:0]  OUT_TAG,
  output logic             BUSY
);

  localparam int LEVELS = clog4(WIDTH);

  // Index k is the boundary in front of level k; index LEVELS is the block output.
  logic [LEVELS:0] vld_w;
  logic [LEVELS:0] rdy_w;
  logic [TAGW-1:0] tag_w [0:LEVELS];

  assign vld_w[0]      = IN_VALID;
  assign tag_w[0]      = IN_TAG;
  assign IN_READY      = rdy_w[0];
  assign rdy_w[LEVELS] = OUT_READY;

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int WI = level_width(WIDTH, k);
    localparam int WO = level_width(WIDTH, k + 1);

    logic [WI-1:0] din;
    logic [WO-1:0] dout;

    if (k == 0) begin : g_src
      assign din = IN_DATA;
    end else begin : g_chain
      assign din = g_lvl[k-1].dout;
    end

    gtech_and4_pipe_stage #(
      .WIN  (WI),
      .TAGW (TAGW)
    ) u_stage (
      .clk_i    (CP),
      .rst_ni   (CD),
      .up_vld_i (vld_w[k]),
      .up_rdy_o (rdy_w[k]),
      .up_dat_i (din),
      .up_tag_i (tag_w[k]),
      .dn_vld_o (vld_w[k+1]),
      .dn_rdy_i (rdy_w[k+1]),
      .dn_dat_o (dout),
      .dn_tag_o (tag_w[k+1])
    );

    if (k == LEVELS - 1) begin : g_last
      assign Z = dout[0];
    end
  end

  assign OUT_VALID = vld_w[LEVELS];
  assign OUT_TAG   = tag_w[LEVELS];
  assign BUSY      = |vld_w[LEVELS:1];

endmodule

// File: doc/gtech_and4_tree_pipe.md
Name: gtech_and4_tree_pipe

Overview:
- Pipelined, registered wide AND-reduction built from levels of 4-input AND cells (GTECH_AND4), one register stage per level.
- Sits downstream of raw match/compare vectors. Produces a single all-ones flag per accepted word.
- Uses a valid/ready handshake with full throughput and backpressure.
- Carries an opaque tag alongside each word so consumers can correlate results.

Parameters:
- WIDTH, 64, input vector width; legal range 1..1024.
- TAGW, 4, width of the sideband tag passed through with each word; legal range 1..32.
- LEVELS, derived (not overridable), max(1, ceil(log4(WIDTH))); equals 3 for WIDTH=64.

Ports:
- CP  in  1  clock, rising edge.
- CD  in  1  reset, asynchronous, active-low.
- IN_VALID  in  1  input word valid.
- IN_READY  out  1  block can accept the input word this cycle.
- IN_DATA  in  WIDTH  vector to be AND-reduced.
- IN_TAG  in  TAGW  sideband tag.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer accepts the result this cycle.
- Z  out  1  AND of all IN_DATA bits of the corresponding word.
- OUT_TAG  out  TAGW  tag of the corresponding word.
- BUSY  out  1  at least one stage holds a valid word.

Behaviour:
- Level k (k=0..LEVELS-1):
  - Groups its input bits into fours, LSB-first, and ANDs each group.
  - Pads missing bits of the last group with 1.
  - Width out of level k is ceil(width_in/4).
  - Level LEVELS-1 output is exactly 1 bit, which drives Z.
- Each level owns a register holding data, tag and a valid bit v[k].
- Transfer rules:
  - Input transfer: IN_VALID & IN_READY.
  - Output transfer: OUT_VALID & OUT_READY.
- Stall rule:
  - Stage k loads when (!v[k] | adv[k+1]).
  - adv[LEVELS] = OUT_READY.
  - adv[k] = v[k-1] & load condition of stage k.
  - IN_READY = !v[0] | adv[1]. It is combinational from OUT_READY through the valid chain; no skid buffer.
  - v[k] clears when stage k's word moves on and nothing replaces it.
- Derived outputs:
  - OUT_VALID = v[LEVELS-1].
  - Z and OUT_TAG come from the last stage register; they are stable while OUT_VALID & !OUT_READY.
  - BUSY = OR of all v[k].
- Latency: exactly LEVELS cycles from input transfer to OUT_VALID, with no stalls.
- Throughput: one word per cycle when OUT_READY is held high.
- Ordering: strictly in order; no word is dropped or duplicated.
- Reset (CD low, asynchronous):
  - All v[k]=0, all data and tag registers=0.
  - OUT_VALID=0, Z=0, OUT_TAG=0, BUSY=0.
  - IN_READY=1 combinationally once CD is low.
- Reset mid-operation: all in-flight words are discarded silently. The first word accepted after CD rises emerges LEVELS cycles later.
- Boundary conditions:
  - Simultaneous input transfer and output transfer with a full pipe: both occur and the pipe stays full.
  - Full pipe with OUT_READY=0: IN_READY=0, and no register changes except those of empty stages.
  - WIDTH=1: LEVELS=1 and Z = registered IN_DATA[0].
  - WIDTH not a power of 4: padding with 1s must not force Z=0.
- Data registers of empty stages may load don't-care data. Z and OUT_TAG are only meaningful while OUT_VALID=1.

Decomposition:
- Package gtech_tree_pkg:
  - Function clog4(n).
  - Function level_width(width, k).
  - Constant FANIN=4.
- Sub-module gtech_and4_pipe_stage:
  - Parameters WIN and TAGW.
  - Contains the AND4 group array with padding, the data/tag/valid register, and the load/advance logic.
- Top module: instantiates the stages in a generate loop and wires the ready chain.

Test Plan:
- Single word 0xFFFF_FFFF_FFFF_FFFF, tag 0x5, OUT_READY=1 -> OUT_VALID rises exactly 3 cycles after accept, Z=1, OUT_TAG=0x5, BUSY drops the following cycle.
- Stream of 8 back-to-back words; word i has bit i cleared for even i and is all-ones for odd i; tags 0..7 -> 8 consecutive results, Z=0,1,0,1,0,1,0,1, tags in order, IN_READY constantly 1.
- Fill the pipe, then OUT_READY=0 for 5 cycles -> after 3 accepts IN_READY=0; Z and OUT_TAG hold steady; on release all words drain in order with none lost.
- WIDTH=5, IN_DATA=5'b11111 -> Z=1; IN_DATA=5'b01111 -> Z=0 (padding check), LEVELS=2.
- Pull CD low with 2 words in flight -> OUT_VALID=0, BUSY=0, Z=0 immediately. After release, a new word with tag 0x9 is the only result observed.
- Random valid/ready toggling against a scoreboard for 10k words -> no mismatch, drop or duplicate.
